// File: rtl/panel_capture_if.sv
// Panel-side signals and framebuffer write port of the panel capture block.
// The master side drives the panel pins and consumes the pixel writes.
interface panel_capture_if;
  logic        panel_clk;
  logic        panel_lat;
  logic        panel_oe_n;
  logic [5:0]  panel_rgb;
  logic [2:0]  panel_abc;

  logic        wr_en;
  logic [2:0]  wr_line;
  logic [5:0]  wr_col;
  logic [5:0]  wr_data;
  logic        frame_done;
  logic        len_err;
  logic        overrun;
  logic [15:0] oe_active;

  modport master (
    output panel_clk, panel_lat, panel_oe_n, panel_rgb, panel_abc,
    input  wr_en, wr_line, wr_col, wr_data, frame_done, len_err, overrun, oe_active
  );

  modport slave (
    input  panel_clk, panel_lat, panel_oe_n, panel_rgb, panel_abc,
    output wr_en, wr_line, wr_col, wr_data, frame_done, len_err, overrun, oe_active
  );
endinterface

// File: rtl/panel_capture.sv
// Oversampling receiver for the LED panel shift/latch interface: rebuilds each latched
// 64-column line and streams it out as one framebuffer write per clk_in cycle.
module panel_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COLS        = 64
) (
  input logic             clk_in,
  input logic             reset,
  panel_capture_if.slave  io_bus
);

  localparam int unsigned InW = 12;

  typedef enum logic [1:0] {StIdle, StDump} state_e;

  // {clk, lat, oe_n, rgb[5:0], abc[2:0]} travel through one shared synchronizer chain
  logic [InW-1:0]                  w_raw;
  logic [SYNC_STAGES-1:0][InW-1:0] r_sync;
  logic [InW-1:0]                  w_s;
  logic                            w_s_clk;
  logic                            w_s_lat;
  logic                            w_s_oe_n;
  logic [5:0]                      w_s_rgb;
  logic [2:0]                      w_s_abc;

  logic r_prev_clk;
  logic r_prev_lat;
  logic w_clk_rise;
  logic w_lat_rise;

  logic [COLS-1:0][5:0] r_shift;
  logic [COLS-1:0][5:0] w_shift_nxt;
  logic [COLS-1:0][5:0] r_latch;
  logic [2:0]           r_line;
  logic [6:0]           r_bit_cnt;
  logic [6:0]           w_cnt_nxt;
  logic                 r_len_err;
  logic                 r_overrun;
  logic [15:0]          r_oe_active;

  state_e     r_state;
  state_e     w_state_d;
  logic [5:0] r_col;
  logic [5:0] w_col_d;
  logic       w_wr_en;
  logic       w_frame_done;

  assign w_raw = {io_bus.panel_clk, io_bus.panel_lat, io_bus.panel_oe_n,
                  io_bus.panel_rgb, io_bus.panel_abc};

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_sync     <= '0;
      r_prev_clk <= 1'b0;
      r_prev_lat <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], w_raw};
      r_prev_clk <= w_s_clk;
      r_prev_lat <= w_s_lat;
    end
  end

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_s_clk    = w_s[11];
  assign w_s_lat    = w_s[10];
  assign w_s_oe_n   = w_s[9];
  assign w_s_rgb    = w_s[8:3];
  assign w_s_abc    = w_s[2:0];
  assign w_clk_rise = w_s_clk & ~r_prev_clk;
  assign w_lat_rise = w_s_lat & ~r_prev_lat;

  // A shift coinciding with the latch is part of the latched line and of its length count
  assign w_shift_nxt = w_clk_rise ? {r_shift[COLS-2:0], w_s_rgb} : r_shift;
  assign w_cnt_nxt   = (w_clk_rise && (r_bit_cnt != 7'd127)) ? r_bit_cnt + 7'd1 : r_bit_cnt;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_latch   <= '0;
      r_line    <= '0;
      r_bit_cnt <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_lat_rise ? 7'd0 : w_cnt_nxt;
      r_len_err <= w_lat_rise && (w_cnt_nxt != 7'(COLS));
      if (w_lat_rise) begin
        r_latch <= w_shift_nxt;
        r_line  <= w_s_abc;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_col   <= '0;
    end else begin
      r_state <= w_state_d;
      r_col   <= w_col_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_col_d      = r_col;
    w_wr_en      = 1'b0;
    w_frame_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_lat_rise) begin
          w_state_d = StDump;
          w_col_d   = 6'd0;
        end
      end
      StDump: begin
        w_wr_en      = 1'b1;
        w_frame_done = (r_col == 6'(COLS - 1)) && (r_line == 3'd7);
        // A fresh latch mid-dump abandons the rest of the current line
        if (w_lat_rise) begin
          w_col_d = 6'd0;
        end else if (r_col == 6'(COLS - 1)) begin
          w_state_d = StIdle;
          w_col_d   = 6'd0;
        end else begin
          w_col_d = r_col + 6'd1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_col_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_oe_active <= '0;
    end else begin
      if (w_lat_rise && (r_state == StDump)) begin
        r_overrun <= 1'b1;
      end
      if (w_frame_done) begin
        r_oe_active <= '0;
      end else if (!w_s_oe_n && (r_oe_active != 16'hFFFF)) begin
        r_oe_active <= r_oe_active + 16'd1;
      end
    end
  end

  assign io_bus.wr_en      = w_wr_en;
  assign io_bus.wr_line    = w_wr_en ? r_line : 3'd0;
  assign io_bus.wr_col     = w_wr_en ? r_col : 6'd0;
  assign io_bus.wr_data    = w_wr_en ? r_latch[r_col] : 6'd0;
  assign io_bus.frame_done = w_frame_done;
  assign io_bus.len_err    = r_len_err;
  assign io_bus.overrun    = r_overrun;
  assign io_bus.oe_active  = r_oe_active;

endmodule

// File: tb/tb_panel_capture.sv
// Randomized bench for panel_capture: drives panel shift/latch traffic and checks the
// pixel writes against a history-of-shifted-pixels model.
module tb_panel_capture;
  localparam int unsigned S = 2;
  localparam int unsigned H = S + 2;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;

  panel_capture_if bus ();

  panel_capture #(
    .SYNC_STAGES(S),
    .COLS       (64)
  ) dut (
    .clk_in(clk_in),
    .reset (reset),
    .io_bus(bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Model: the last 64 shifted pixels (newest at the back) and clocks since last latch
  logic [5:0] hist[$];
  int         clk_cnt = 0;
  logic [5:0] exp_line [64];
  logic       oe_rand = 1'b0;

  // Write log and event counters, filled only by the monitor
  int   w_line[$];
  int   w_col[$];
  int   w_data[$];
  int   w_cyc[$];
  int   cyc = 0;
  int   le_n = 0;
  int   le_col0 = 0;
  int   fd_good = 0;
  int   fd_bad = 0;
  int   fd_oe = 0;
  int   fd_oe_next = 0;
  int   oe_low_n = 0;
  logic fd_prev = 1'b0;

  always @(negedge clk_in) begin
    cyc <= cyc + 1;
    if (bus.wr_en) begin
      w_line.push_back(int'(bus.wr_line));
      w_col.push_back(int'(bus.wr_col));
      w_data.push_back(int'(bus.wr_data));
      w_cyc.push_back(cyc);
    end
    if (bus.len_err) begin
      le_n <= le_n + 1;
      if (bus.wr_en && bus.wr_col == 6'd0) le_col0 <= le_col0 + 1;
    end
    if (bus.frame_done) begin
      if (bus.wr_en && bus.wr_col == 6'd63 && bus.wr_line == 3'd7) fd_good <= fd_good + 1;
      else fd_bad <= fd_bad + 1;
      fd_oe <= int'(bus.oe_active);
    end
    if (fd_prev) fd_oe_next <= int'(bus.oe_active);
    fd_prev <= bus.frame_done;
    if (!bus.panel_oe_n) oe_low_n <= oe_low_n + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic model_shift(input logic [5:0] pix);
    hist.push_back(pix);
    if (hist.size() > 64) void'(hist.pop_front());
    if (clk_cnt < 127) clk_cnt++;
  endtask

  task automatic snap_latch();
    for (int c = 0; c < 64; c++)
      exp_line[c] = (c < hist.size()) ? hist[hist.size() - 1 - c] : 6'd0;
    clk_cnt = 0;
  endtask

  task automatic panel_clock(input logic [5:0] pix);
    bus.panel_rgb = pix;
    if (oe_rand) bus.panel_oe_n = 1'($urandom_range(0, 1));
    tick(2);
    bus.panel_clk = 1'b1;
    model_shift(pix);
    tick(H);
    bus.panel_clk = 1'b0;
    if (oe_rand) bus.panel_oe_n = 1'($urandom_range(0, 1));
    tick(H);
  endtask

  task automatic random_clocks(input int n);
    for (int k = 0; k < n; k++) panel_clock(6'($urandom));
  endtask

  task automatic panel_latch(input logic [2:0] abc);
    bus.panel_abc = abc;
    tick(2);
    bus.panel_lat = 1'b1;
    snap_latch();
    tick(H);
    bus.panel_lat = 1'b0;
    tick(H);
  endtask

  // Waits for one full line of writes after index base and counts deviations from the model
  task automatic score_dump(input int base, input int line, output int n, output int errs);
    int t = 0;
    while (w_line.size() < base + 64 && t < 300) begin
      tick(1);
      t++;
    end
    tick(3);
    n    = w_line.size() - base;
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      if (base + i >= w_line.size()) errs++;
      else if (w_col[base+i] != i || w_line[base+i] != line ||
               w_data[base+i] != int'(exp_line[i]) ||
               (i > 0 && w_cyc[base+i] != w_cyc[base+i-1] + 1)) errs++;
    end
  endtask

  task automatic test_reset();
    bus.panel_clk  = 1'b0;
    bus.panel_lat  = 1'b0;
    bus.panel_oe_n = 1'b1;
    bus.panel_rgb  = '0;
    bus.panel_abc  = '0;
    tick(3);
    checks++;
    if ({bus.wr_en, bus.frame_done, bus.len_err, bus.overrun} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus.wr_en, bus.frame_done, bus.len_err, bus.overrun});
    end
    checks++;
    if ({bus.wr_line, bus.wr_col, bus.wr_data} !== 15'd0) begin
      errors++;
      $display("FAIL reset_wr_bus: got %h expected 0", {bus.wr_line, bus.wr_col, bus.wr_data});
    end
    checks++;
    if (bus.oe_active !== 16'd0) begin
      errors++;
      $display("FAIL reset_oe_active: got %0d expected 0", bus.oe_active);
    end
    reset = 1'b0;
    tick(3);
    checks++;
    if (bus.wr_en !== 1'b0 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got wr_en %b overrun %b expected 0 0",
               bus.wr_en, bus.overrun);
    end
  endtask

  task automatic test_basic();
    int base, le0, n, errs, bad;
    base = w_line.size();
    le0  = le_n;
    for (int k = 0; k < 64; k++) panel_clock(6'(k));
    panel_latch(3'd3);
    score_dump(base, 3, n, errs);
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL basic_count: got %0d writes expected 64", n);
    end
    checks++;
    if (errs != 0) begin
      errors++;
      $display("FAIL basic_model: got %0d bad writes expected 0", errs);
    end
    bad = 0;
    for (int c = 0; c < 64 && base + c < w_data.size(); c++)
      if (w_data[base+c] != 63 - c) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_data_63_minus_col: got %0d bad expected 0", bad);
    end
    checks++;
    if (le_n - le0 != 0 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: got len_err %0d overrun %b expected 0 0", le_n - le0,
               bus.overrun);
    end
  endtask

  task automatic test_frame();
    int fdg0, fdb0, oe0, le0, n, errs, tot;
    for (int pass = 0; pass < 2; pass++) begin
      fdg0 = fd_good;
      fdb0 = fd_bad;
      le0  = le_n;
      oe0  = oe_low_n;
      tot  = 0;
      oe_rand = (pass == 1);
      for (int line = 0; line < 8; line++) begin
        int base;
        if (line == 7) begin
          oe_rand        = 1'b0;
          bus.panel_oe_n = 1'b1;
        end
        base = w_line.size();
        random_clocks(64);
        panel_latch(3'(line));
        score_dump(base, line, n, errs);
        tot += errs + ((n == 64) ? 0 : 1);
      end
      checks++;
      if (tot != 0) begin
        errors++;
        $display("FAIL frame_lines pass %0d: got %0d bad writes expected 0", pass, tot);
      end
      checks++;
      if (fd_good - fdg0 != 1 || fd_bad - fdb0 != 0) begin
        errors++;
        $display("FAIL frame_done pass %0d: got good %0d stray %0d expected 1 0", pass,
                 fd_good - fdg0, fd_bad - fdb0);
      end
      checks++;
      if (le_n - le0 != 0) begin
        errors++;
        $display("FAIL frame_len_err pass %0d: got %0d expected 0", pass, le_n - le0);
      end
      if (pass == 1) begin
        checks++;
        if (fd_oe != oe_low_n - oe0) begin
          errors++;
          $display("FAIL oe_active_count: got %0d expected %0d", fd_oe, oe_low_n - oe0);
        end
        checks++;
        if (fd_oe_next != 0) begin
          errors++;
          $display("FAIL oe_active_clear: got %0d expected 0", fd_oe_next);
        end
      end
    end
  endtask

  task automatic test_len_err();
    int base, le0, c00, n, errs;
    base = w_line.size();
    le0  = le_n;
    c00  = le_col0;
    random_clocks(63);
    panel_latch(3'd1);
    score_dump(base, 1, n, errs);
    checks++;
    if (le_n - le0 != 1 || le_col0 - c00 != 1) begin
      errors++;
      $display("FAIL len_err_63: got pulses %0d at_col0 %0d expected 1 1", le_n - le0,
               le_col0 - c00);
    end
    checks++;
    if (errs != 0 || n != 64) begin
      errors++;
      $display("FAIL len_err_63_data: got %0d bad %0d writes expected 0 64", errs, n);
    end
    base = w_line.size();
    le0  = le_n;
    random_clocks(130);
    panel_latch(3'd4);
    score_dump(base, 4, n, errs);
    checks++;
    if (le_n - le0 != 1) begin
      errors++;
      $display("FAIL len_err_130: got %0d pulses expected 1", le_n - le0);
    end
    checks++;
    if (errs != 0 || n != 64) begin
      errors++;
      $display("FAIL len_err_130_data: got %0d bad %0d writes expected 0 64", errs, n);
    end
  endtask

  task automatic test_overrun();
    int base, t, n, errs, late;
    random_clocks(64);
    base = w_line.size();
    bus.panel_abc = 3'd2;
    tick(2);
    bus.panel_lat = 1'b1;
    snap_latch();
    tick(H);
    bus.panel_lat = 1'b0;
    tick(H);
    bus.panel_abc = 3'd6;
    tick(20 - 2 * H);
    bus.panel_lat = 1'b1;
    snap_latch();
    tick(H);
    bus.panel_lat = 1'b0;
    t = 0;
    while (w_line.size() < base + 84 && t < 300) begin
      tick(1);
      t++;
    end
    tick(3);
    n    = w_line.size() - base;
    errs = 0;
    late = 0;
    for (int i = 0; i < n; i++) begin
      if (w_line[base+i] == 2 && w_col[base+i] > 19) late++;
      if (i < 20) begin
        if (w_line[base+i] != 2 || w_col[base+i] != i || w_data[base+i] != int'(exp_line[i]))
          errs++;
      end else if (i < 84) begin
        if (w_line[base+i] != 6 || w_col[base+i] != i - 20 ||
            w_data[base+i] != int'(exp_line[i-20])) errs++;
      end
    end
    checks++;
    if (n != 84 || errs != 0) begin
      errors++;
      $display("FAIL overrun_restart: got %0d writes %0d bad expected 84 0", n, errs);
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL overrun_first_line_cut: got %0d writes past col 19 expected 0", late);
    end
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b expected 1", bus.overrun);
    end
    tick(50);
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b expected 1", bus.overrun);
    end
  endtask

  task automatic test_coincident();
    int base, le0, n, errs;
    logic [5:0] pix;
    random_clocks(63);
    base = w_line.size();
    le0  = le_n;
    pix  = 6'($urandom);
    bus.panel_rgb = pix;
    bus.panel_abc = 3'd0;
    tick(2);
    bus.panel_clk = 1'b1;
    bus.panel_lat = 1'b1;
    model_shift(pix);
    snap_latch();
    tick(H);
    bus.panel_clk = 1'b0;
    bus.panel_lat = 1'b0;
    tick(H);
    score_dump(base, 0, n, errs);
    checks++;
    if (n < 1 || w_col[base] != 0 || w_data[base] != int'(pix)) begin
      errors++;
      $display("FAIL coincident_col0: got %0d expected %0d",
               (n < 1) ? -1 : w_data[base], pix);
    end
    checks++;
    if (errs != 0 || le_n - le0 != 0) begin
      errors++;
      $display("FAIL coincident_line: got %0d bad len_err %0d expected 0 0", errs, le_n - le0);
    end
  endtask

  task automatic test_reset_mid();
    int base, le0, n, errs, t;
    logic found;
    random_clocks(64);
    base  = w_line.size();
    found = 1'b0;
    panel_latch(3'd5);
    t = 0;
    while (!found && t < 200) begin
      @(negedge clk_in);
      if (bus.wr_en && bus.wr_col == 6'd30) found = 1'b1;
      t++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_reach_col30: got no col 30 write expected one");
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.wr_en, bus.frame_done, bus.len_err, bus.overrun, bus.wr_line, bus.wr_col,
         bus.wr_data, bus.oe_active} !== 35'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got wr_en %b col %0d overrun %b expected all 0",
               bus.wr_en, bus.wr_col, bus.overrun);
    end
    tick(3);
    reset = 1'b0;
    hist.delete();
    clk_cnt = 0;
    tick(5);
    checks++;
    if (w_line.size() - base != 31) begin
      errors++;
      $display("FAIL reset_mid_abort: got %0d writes expected 31", w_line.size() - base);
    end
    base = w_line.size();
    le0  = le_n;
    panel_latch(3'd2);
    score_dump(base, 2, n, errs);
    checks++;
    if (n != 64 || errs != 0) begin
      errors++;
      $display("FAIL reset_zero_line: got %0d writes %0d bad expected 64 0", n, errs);
    end
    checks++;
    if (le_n - le0 != 1 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_zero_flags: got len_err %0d overrun %b expected 1 0", le_n - le0,
               bus.overrun);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_frame();
    test_len_err();
    test_overrun();
    test_coincident();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
